keccak_sponge_ctrl: RTL
=======================

Name: keccak_sponge_ctrl

Overview:
Sponge sequencer that sits directly upstream of the Keccak permutation core and its round controller. It accepts a lane-serial message stream and XORs each lane into the core state. It applies pad10*1 with a domain byte, starts and awaits each permutation through the core's reset/Ready handshake, then squeezes a requested number of output lanes. It holds no Keccak state itself; it only drives lane-indexed XOR writes and reads.

Parameters:
W, 64, lane width in bits; must be at least 8.
RATE_LANES, 21, rate in lanes; legal range 1..24 (21 = SHAKE128 at W=64).
DS, 8'h1F, domain-separation byte XORed into the lane LSBs at padding.
LEN_W, 16, width of the output-length counter.

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Start  in  1  one-cycle request to begin a new hash; honoured only in IDLE or DONE
StartEmpty  in  1  sampled with Start; 1 = zero-length message
OutLanes  in  LEN_W  number of output lanes to squeeze; sampled with Start
InValid  in  1  message lane valid
InReady  out  1  message lane accepted
InData  in  W  message lane
InLast  in  1  marks the final message lane
ClearState  out  1  one-cycle pulse; the core zeroes its state
LaneXorEn  out  1  core XORs LaneXorData into lane LaneIdx
LaneIdx  out  5  lane index for XOR and read
LaneXorData  out  W  XOR operand
LaneRdData  in  W  core lane[LaneIdx], combinational
PermReset  out  1  registered; drives the core controller's active-high Reset
PermReady  in  1  core controller's Ready
OutValid  out  1  squeeze lane valid
OutReady  in  1  squeeze lane accepted
OutData  out  W  equals LaneRdData
OutLast  out  1  marks the final squeeze lane
Busy  out  1  high in any state except IDLE and DONE
Done  out  1  level output, high in DONE

Behaviour:
- Reset (Reset=0, async): state IDLE; PermReset=1; all counters 0; flags 0. All other outputs are 0. A reset mid-operation aborts immediately; the core is held in reset by PermReset.
- States: IDLE, ABSORB, PAD_DS, PAD_END, PERM_A, SQUEEZE, PERM_S, DONE.
- IDLE/DONE + Start:
  - ClearState=1 for that cycle.
  - Latch OutLanes into Remaining; LaneCnt=0; PadPending=0.
  - Next state is PAD_DS if StartEmpty=1, else ABSORB.
  - Start in any other state is ignored.
- ABSORB:
  - InReady=1. LaneIdx=LaneCnt, LaneXorData=InData, LaneXorEn=InValid.
  - On handshake with LaneCnt=RATE_LANES-1: LaneCnt<=0; PadPending<=InLast; go to PERM_A.
  - Else, on handshake with InLast: LaneCnt++; go to PAD_DS.
  - Else, on handshake: LaneCnt++.
- PAD_DS (1 cycle): XOR {0..,DS} at LaneIdx=LaneCnt; go to PAD_END.
- PAD_END (1 cycle): XOR 1<<(W-1) at LaneIdx=RATE_LANES-1; set Final=1; go to PERM_A. When both pad writes hit the same lane, the XORs combine correctly.
- PERM_A/PERM_S:
  - PermReset=0 from the cycle after entry.
  - On PermReady=1: PermReset<=1.
  - PERM_A exits as follows: to PAD_DS with LaneCnt=0 if PadPending (then clear PadPending); to SQUEEZE if Final; otherwise to ABSORB.
  - PERM_S exits to SQUEEZE with LaneCnt=0.
  - PermReset is high for at least one cycle between permutations.
- SQUEEZE:
  - If Remaining=0 on entry, go to DONE directly.
  - OutValid=1; LaneIdx=LaneCnt; OutLast=(Remaining==1).
  - On handshake: Remaining--; LaneCnt++. Then go to DONE if Remaining becomes 0, else to PERM_S if LaneCnt was RATE_LANES-1.
  - With OutReady=0, OutData and LaneIdx hold.
- InReady=0 and LaneXorEn=0 outside ABSORB/PAD_*. OutValid=0 outside SQUEEZE.

Decomposition:
- Package keccak_sponge_pkg holds:
  - the state encoding
  - the pad constants (DS, MSB mask)
  - lane-index width 5
  - the RATE_LANES legality check
- No sub-module: the FSM and counters live in one module. The permutation core and keccak_control are instantiated by the parent.

Test Plan:
1. Empty message (W=64, RATE_LANES=21, StartEmpty=1, OutLanes=2) -> the following sequence:
   - XOR 0x1F at lane0, then 0x8000_0000_0000_0000 at lane20.
   - PermReset low until PermReady.
   - Two out beats, LaneIdx 0 then 1; OutLast on beat 2.
   - Done=1.
2. Three-lane message (0x11,0x22,0x33, InLast on 3rd) -> XORs at lanes 0,1,2, then DS at lane3 and MSB at lane20, then one permutation, then squeeze.
3. Exactly 21 lanes with InLast on lane20 -> PERM_A, then pad at lane0/lane20, then a second PERM_A, then SQUEEZE.
4. OutLanes=22 -> 21 beats, PERM_S (PermReset 1->0->1), then 1 beat at LaneIdx 0 with OutLast; OutLanes=0 -> no beats, Done after the final permutation.
5. OutReady low for 5 cycles mid-squeeze -> OutValid held; OutData/LaneIdx stable; Remaining unchanged.
6. Reset low during PERM_A -> same cycle: PermReset=1, Busy=0, InReady=0. After Reset rises, Start runs a fresh hash; Start pulsed while Busy is ignored.

Source files
------------

// File: rtl/keccak_sponge_pkg.sv
// keccak_sponge_pkg
//   Shared definitions for the Keccak sponge sequencer:
//   - FSM state encoding
//   - default domain-separation byte (SHAKE)
//   - lane-index width
//   - helpers for the pad lanes and the rate legality check
package keccak_sponge_pkg;

    // Five bits address all 25 lanes of the Keccak-f state.
    localparam int LIDX_W = 5;

    // SHAKE domain byte: the "1111" suffix followed by the first pad bit.
    localparam logic [7:0] DS_SHAKE = 8'h1F;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ABSORB  = 3'd1,
        S_PAD_DS  = 3'd2,
        S_PAD_END = 3'd3,
        S_PERM_A  = 3'd4,
        S_SQUEEZE = 3'd5,
        S_PERM_S  = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    // The rate must leave at least one lane of capacity.
    function automatic bit rate_legal(input int rate);
        return (rate >= 1) && (rate <= 24);
    endfunction

endpackage

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl
//   Lane-serial sponge sequencer in front of a Keccak permutation core.
//   It owns no state bits of the permutation; it only issues lane-indexed
//   XOR writes/reads and sequences the core through its reset/Ready handshake.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                begin a new hash (honoured in IDLE/DONE only)
//   start_empty_i          sampled with start: zero-length message
//   out_lanes_i            sampled with start: number of lanes to squeeze
//   in_valid_i/in_ready_o  message lane handshake, in_data_i, in_last_i
//   clear_state_o          one-cycle pulse: core zeroes its state
//   lane_xor_en_o          core XORs lane_xor_data_o into lane lane_idx_o
//   lane_idx_o             lane index for both XOR and read
//   lane_rd_data_i         core lane[lane_idx_o], combinational
//   perm_reset_o           registered active-high reset to the round controller
//   perm_ready_i           round controller Ready
//   out_valid_o/out_ready_i squeeze lane handshake, out_data_o, out_last_o
//   busy_o, done_o         status
module keccak_sponge_ctrl
    import keccak_sponge_pkg::*;
#(
    parameter int         W          = 64,
    parameter int         RATE_LANES = 21,
    parameter logic [7:0] DS         = DS_SHAKE,
    parameter int         LEN_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              start_empty_i,
    input  logic [LEN_W-1:0]  out_lanes_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W-1:0]      in_data_i,
    input  logic              in_last_i,
    output logic              clear_state_o,
    output logic              lane_xor_en_o,
    output logic [LIDX_W-1:0] lane_idx_o,
    output logic [W-1:0]      lane_xor_data_o,
    input  logic [W-1:0]      lane_rd_data_i,
    output logic              perm_reset_o,
    input  logic              perm_ready_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W-1:0]      out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    if (!rate_legal(RATE_LANES) || (W < 8)) begin : g_bad_param
        $error("keccak_sponge_ctrl: RATE_LANES must be 1..24 and W at least 8");
    end

    localparam logic [LIDX_W-1:0] LAST_LANE   = LIDX_W'(RATE_LANES - 1);
    localparam logic [W-1:0]      PAD_DS_LANE = W'(DS);
    localparam logic [W-1:0]      PAD_MSB     = {1'b1, {(W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [LIDX_W-1:0]  lane_cnt_q, lane_cnt_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               pad_pending_q, pad_pending_d;  // message ended on a full block
    logic               final_q, final_d;              // pad block has been written
    logic               perm_reset_q, perm_reset_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            lane_cnt_q    <= '0;
            remaining_q   <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
            perm_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            lane_cnt_q    <= lane_cnt_d;
            remaining_q   <= remaining_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
            perm_reset_q  <= perm_reset_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        lane_cnt_d      = lane_cnt_q;
        remaining_d     = remaining_q;
        pad_pending_d   = pad_pending_q;
        final_d         = final_q;
        perm_reset_d    = perm_reset_q;
        in_ready_o      = 1'b0;
        clear_state_o   = 1'b0;
        lane_xor_en_o   = 1'b0;
        lane_idx_o      = '0;
        lane_xor_data_o = '0;
        out_valid_o     = 1'b0;
        out_last_o      = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    clear_state_o = 1'b1;
                    remaining_d   = out_lanes_i;
                    lane_cnt_d    = '0;
                    pad_pending_d = 1'b0;
                    final_d       = 1'b0;
                    state_d       = start_empty_i ? S_PAD_DS : S_ABSORB;
                end
            end

            S_ABSORB: begin
                in_ready_o      = 1'b1;
                lane_idx_o      = lane_cnt_q;
                lane_xor_data_o = in_data_i;
                lane_xor_en_o   = in_valid_i;
                if (in_valid_i) begin
                    if (lane_cnt_q == LAST_LANE) begin
                        // Block full: permute first; a final lane here means
                        // the padding goes into a fresh block afterwards.
                        lane_cnt_d    = '0;
                        pad_pending_d = in_last_i;
                        state_d       = S_PERM_A;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                        if (in_last_i) state_d = S_PAD_DS;
                    end
                end
            end

            S_PAD_DS: begin
                lane_xor_en_o   = 1'b1;
                lane_idx_o      = lane_cnt_q;
                lane_xor_data_o = PAD_DS_LANE;
                state_d         = S_PAD_END;
            end

            // Separate cycle from PAD_DS, so if both land on the last lane
            // the core simply XORs twice and the bits combine.
            S_PAD_END: begin
                lane_xor_en_o   = 1'b1;
                lane_idx_o      = LAST_LANE;
                lane_xor_data_o = PAD_MSB;
                final_d         = 1'b1;
                state_d         = S_PERM_A;
            end

            S_PERM_A, S_PERM_S: begin
                // perm_reset_q is always high on entry; drop it one cycle
                // later and ignore Ready until the core has left reset.
                if (perm_reset_q) begin
                    perm_reset_d = 1'b0;
                end else if (perm_ready_i) begin
                    perm_reset_d = 1'b1;
                    lane_cnt_d   = '0;
                    if (state_q == S_PERM_S) begin
                        state_d = S_SQUEEZE;
                    end else if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        state_d       = S_PAD_DS;
                    end else if (final_q) begin
                        state_d = S_SQUEEZE;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end

            S_SQUEEZE: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    out_valid_o = 1'b1;
                    lane_idx_o  = lane_cnt_q;
                    out_last_o  = (remaining_q == LEN_W'(1));
                    if (out_ready_i) begin
                        remaining_d = remaining_q - 1'b1;
                        lane_cnt_d  = lane_cnt_q + 1'b1;
                        if (remaining_q == LEN_W'(1))  state_d = S_DONE;
                        else if (lane_cnt_q == LAST_LANE) state_d = S_PERM_S;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign out_data_o   = out_valid_o ? lane_rd_data_i : '0;
    assign perm_reset_o = perm_reset_q;
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);

endmodule
